// File: rtl/patgen_pkg.sv
// patgen_pkg: shared state encoding and default sizing for pattern_generator.
package patgen_pkg;
    typedef enum logic {PG_IDLE, PG_RUN} pg_state_e;
    localparam int PG_DEPTH = 8;
    localparam int PG_WIDTH = 4;
    localparam int PG_DIV_W = 8;
endpackage

// File: rtl/pattern_generator_if.sv
// pattern_generator_if: control, write and playback signals of pattern_generator.
// The loop input only exists when PATGEN_LOOP_EN is defined.
interface pattern_generator_if import patgen_pkg::*; #(
    parameter int DEPTH = PG_DEPTH,
    parameter int WIDTH = PG_WIDTH,
    parameter int DIV_W = PG_DIV_W,
    localparam int AW = $clog2(DEPTH)
) ();
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    len;
    logic [DIV_W-1:0] div;
`ifdef PATGEN_LOOP_EN
    logic             loop;
`endif
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_data, len, div, start, stop,
`ifdef PATGEN_LOOP_EN
        output loop,
`endif
        input out_data, out_valid, busy, done
    );

    modport slave (
        input wr_en, wr_addr, wr_data, len, div, start, stop,
`ifdef PATGEN_LOOP_EN
        input loop,
`endif
        output out_data, out_valid, busy, done
    );
endinterface

// File: rtl/patgen_hold_counter.sv
// patgen_hold_counter: loadable down-counter whose zero flag marks a step boundary.
module patgen_hold_counter #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign zero_o = cnt_q == '0;

    always_comb begin
        cnt_d = load_i ? load_val_i : (en_i && !zero_o) ? cnt_q - DIV_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pattern_generator.sv
// pattern_generator: plays a stored word sequence, each word held div+1 cycles.
// Define PATGEN_LOOP_EN to add the loop input and wrap-around playback.
module pattern_generator import patgen_pkg::*; #(
    parameter int DEPTH = PG_DEPTH,
    parameter int WIDTH = PG_WIDTH,
    parameter int DIV_W = PG_DIV_W,
    localparam int AW = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst_n,
    pattern_generator_if.slave pg
);
    pg_state_e        state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    len_q, len_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             cnt_load, cnt_en, cnt_zero;
    logic [DIV_W-1:0] cnt_val;
    logic             loop_q;
`ifdef PATGEN_LOOP_EN
    logic             loop_d;
`else
    assign loop_q = 1'b0;
`endif

    patgen_hold_counter #(.DIV_W(DIV_W)) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    assign pg.out_data  = out_q;
    assign pg.busy      = state_q == PG_RUN;
    assign pg.out_valid = state_q == PG_RUN;
    assign pg.done      = done_q;

    // Step loads read mem_q, i.e. contents from before a same-edge write.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        div_d    = div_q;
`ifdef PATGEN_LOOP_EN
        loop_d   = loop_q;
`endif
        out_d    = out_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = div_q;
        if (state_q == PG_IDLE) begin
            if (pg.start && !pg.stop) begin
                state_d  = PG_RUN;
                len_d    = pg.len;
                div_d    = pg.div;
`ifdef PATGEN_LOOP_EN
                loop_d   = pg.loop;
`endif
                idx_d    = '0;
                out_d    = mem_q[0];
                cnt_load = 1'b1;
                cnt_val  = pg.div;
            end
        end else if (pg.stop) begin
            state_d = PG_IDLE;
            out_d   = '0;
        end else if (!cnt_zero) begin
            cnt_en = 1'b1;
        end else if (idx_q < len_q || loop_q) begin
            idx_d    = idx_q < len_q ? idx_q + AW'(1) : '0;
            out_d    = mem_q[idx_d];
            cnt_load = 1'b1;
        end else begin
            state_d = PG_IDLE;
            out_d   = '0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PG_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            div_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            div_q   <= div_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

`ifdef PATGEN_LOOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) loop_q <= 1'b0;
        else        loop_q <= loop_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (pg.wr_en) begin
            mem_q[pg.wr_addr] <= pg.wr_data;
        end
    end
endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator: directed and random playback checked against a timing-formula model.
module tb_pattern_generator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] data;
        logic       done;
    } exp_t;
    exp_t sb[$];

    bit         m_run = 0;
    bit         m_loop = 0;
    int         m_n, m_len, m_div;
    logic [3:0] m_cur;
    logic [3:0] m_mem [8];

    pattern_generator_if pg_bus ();

    pattern_generator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pg    (pg_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit loop_in();
`ifdef PATGEN_LOOP_EN
        return pg_bus.loop;
`else
        return 1'b0;
`endif
    endfunction

    // Expected outputs after edge e follow from elapsed time since start: t = e - N,
    // step = t/(div+1), and the word is fetched when t is a multiple of div+1.
    task automatic tick();
        int e, t, h;
        e = cyc + 1;
        if (rst_n) begin
            if (m_run && pg_bus.stop) begin
                m_run = 0;
            end else if (m_run) begin
                t = e - m_n;
                h = m_div + 1;
                if (!m_loop && t == (m_len + 1) * h) begin
                    sb.push_back('{e, 4'h0, 1'b1});
                    m_run = 0;
                end else begin
                    if (t % h == 0) m_cur = m_mem[(t / h) % (m_len + 1)];
                    sb.push_back('{e, m_cur, 1'b0});
                end
            end else if (pg_bus.start && !pg_bus.stop) begin
                m_run  = 1;
                m_n    = e;
                m_len  = int'(pg_bus.len);
                m_div  = int'(pg_bus.div);
                m_loop = loop_in();
                m_cur  = m_mem[0];
                sb.push_back('{e, m_cur, 1'b0});
            end
            if (pg_bus.wr_en) m_mem[pg_bus.wr_addr] = pg_bus.wr_data;
        end
        @(negedge clk);
        pg_bus.start = 1'b0;
        pg_bus.stop  = 1'b0;
        pg_bus.wr_en = 1'b0;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(int a, logic [3:0] d);
        pg_bus.wr_en   = 1'b1;
        pg_bus.wr_addr = 3'(a);
        pg_bus.wr_data = d;
        tick();
    endtask

    task automatic go(int l, int d, bit lp);
        pg_bus.len   = 3'(l);
        pg_bus.div   = 8'(d);
`ifdef PATGEN_LOOP_EN
        pg_bus.loop  = lp;
`else
        if (lp) $display("loop requested without PATGEN_LOOP_EN, running one-shot");
`endif
        pg_bus.start = 1'b1;
        tick();
    endtask

    task automatic check_idle_now(string name);
        check({name, "_out"},   32'(pg_bus.out_data),  32'h0);
        check({name, "_valid"}, 32'(pg_bus.out_valid), 32'h0);
        check({name, "_busy"},  32'(pg_bus.busy),      32'h0);
        check({name, "_done"},  32'(pg_bus.done),      32'h0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                check("busy_vs_valid", 32'(pg_bus.busy), 32'(pg_bus.out_valid));
                if (pg_bus.out_valid || pg_bus.done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'(pg_bus.out_valid), 32'h0);
                    end else begin
                        x = sb.pop_front();
                        check("step_cycle", 32'(cyc), 32'(x.cyc));
                        check("out_data", 32'(pg_bus.out_data), 32'(x.data));
                        check("done", 32'(pg_bus.done), 32'(x.done));
                        check("busy", 32'(pg_bus.busy), 32'(!x.done));
                    end
                end else begin
                    check("idle_out_zero", 32'(pg_bus.out_data), 32'h0);
                end
            end
        end
    end

    initial begin
        logic [3:0] pat [4];
        pat[0] = 4'b1010; pat[1] = 4'b0101; pat[2] = 4'b1111; pat[3] = 4'b0000;
        for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
        pg_bus.wr_en = 0; pg_bus.wr_addr = 0; pg_bus.wr_data = 0;
        pg_bus.len = 0; pg_bus.div = 0; pg_bus.start = 0; pg_bus.stop = 0;
`ifdef PATGEN_LOOP_EN
        pg_bus.loop = 0;
`endif
        #1;
        check_idle_now("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) wr(i, pat[i]);
        go(3, 0, 0);
        ticks(6);
        go(3, 2, 0);
        ticks(14);

        pg_bus.start = 1'b1;
        pg_bus.stop  = 1'b1;
        tick();
        check_idle_now("start_stop_idle");

        go(3, 1, 0);
        for (int i = 0; i < 9; i++) begin
            pg_bus.start = i[0];
            pg_bus.len   = 3'(i);
            pg_bus.div   = 8'(i);
            tick();
        end
        ticks(2);

        go(3, 0, 0);
        tick();
        pg_bus.wr_en = 1'b1; pg_bus.wr_addr = 3'd2; pg_bus.wr_data = 4'b0001;
        tick();
        ticks(4);
        go(3, 0, 0);
        ticks(6);

`ifdef PATGEN_LOOP_EN
        go(1, 0, 1);
        ticks(25);
        pg_bus.stop = 1'b1;
        tick();
        check_idle_now("loop_stop");
        ticks(3);
`endif

        go(3, 2, 0);
        ticks(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_now("async_reset");
        m_run = 0;
        sb.delete();
        for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
        ticks(2);
        rst_n = 1'b1;
        go(3, 1, 0);
        ticks(10);

        for (int i = 0; i < 1500; i++) begin
            pg_bus.wr_en   = ($urandom_range(0, 3) == 0);
            pg_bus.wr_addr = 3'($urandom_range(0, 7));
            pg_bus.wr_data = 4'($urandom);
            pg_bus.len     = 3'($urandom_range(0, 7));
            pg_bus.div     = 8'($urandom_range(0, 3));
`ifdef PATGEN_LOOP_EN
            pg_bus.loop    = ($urandom_range(0, 3) == 0);
`endif
            pg_bus.start   = ($urandom_range(0, 7) == 0);
            pg_bus.stop    = ($urandom_range(0, 39) == 0);
            tick();
        end
        pg_bus.stop = 1'b1;
        tick();
        ticks(3);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pattern_generator.md
# pattern_generator

Programmable stimulus source for the logic analyzer's 4-bit probe bus. It plays back a short stored sequence of 4-bit words, each held for a programmable number of clock cycles, so that the trigger/capture path can be exercised on-chip with known patterns such as 4'b1010. It is loaded through a simple write port and started by a one-cycle start pulse. It reports `busy` while playing and pulses `done` when a one-shot run completes.

## Interface
- `DEPTH`, 8: number of pattern words; power of two, 2..16.
- `WIDTH`, 4: width of each pattern word and of `out_data`.
- `DIV_W`, 8: width of the step-hold divider.
- `AW`, $clog2(DEPTH): derived address width; not to be overridden.
- Clock and reset (already decided): one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: write `wr_data` into the pattern word at `wr_addr`.
- `wr_addr`  in  AW: pattern word address.
- `wr_data`  in  WIDTH: pattern word value.
- `len`  in  AW: last step index; a run plays steps 0..`len` (`len`+1 words).
- `div`  in  DIV_W: each step is held for `div`+1 cycles.
- `loop`  in  1: restart at step 0 after step `len` (only with `PATGEN_LOOP_EN`).
- `start`  in  1: begin a run when idle (one-cycle pulse).
- `stop`  in  1: abort a run.
- `out_data`  out  WIDTH: current pattern word; 0 when idle.
- `out_valid`  out  1: high while `out_data` carries a pattern step.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse when a run completes normally.

## Operation
- States: IDLE and RUN. `busy` = (state == RUN). `out_valid` equals `busy`.
- Reset: state IDLE; pattern memory, `out_data`, `out_valid`, `busy`, `done`, step index and hold counter all 0.
- IDLE with `start` sampled high and `stop` low:
  - Go to RUN.
  - Latch `len`, `div` and `loop` into internal registers.
  - Set the step index to 0, load `out_data` = mem[0], and load the hold counter = `div`.
- RUN, each cycle:
  - If the hold counter is nonzero, decrement it.
  - Otherwise, at the step boundary:
    - If the index is below the latched `len`: increment the index, load the next word, and reload the counter.
    - If the index equals `len` and `loop` is set: wrap the index to 0, load mem[0], and reload the counter.
    - If the index equals `len` and `loop` is clear: go to IDLE, clear `out_data` to 0, and assert `done` for one cycle.
- `stop` in RUN has priority over everything else: the next state is IDLE, `out_data` is 0, and `done` is not asserted. `stop` in IDLE has no effect.
- `start` and `stop` high in the same cycle: `stop` wins and the block stays or goes IDLE.
- `start` during RUN is ignored. Changes to `len`, `div` or `loop` during RUN are ignored until the next start.
- Writes are accepted in any state.
  - A step load reads memory contents from before the edge, so a write to the same address on the same edge is seen only on that address's next read.
  - `len` = 0 is legal and plays mem[0] only.
- Reset asserted mid-run: outputs go to reset values immediately; no `done` is issued.

## Timing
- `start` sampled at edge N: `out_data` = mem[0] and `busy`/`out_valid` are high from edge N+1.
- Step k becomes visible at edge N+1+k·(`div`+1).
- One-shot run: `done` is high and `busy` is low at edge N+1+(`len`+1)·(`div`+1). A new `start` is accepted in that same cycle.
- `stop` sampled at edge M: idle outputs appear from edge M+1.
- Write latency: one cycle (word is stored at the write edge).
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `PATGEN_LOOP_EN` defined:
  - The `loop` input and the wrap-around transition exist.
  - Looping runs never assert `done` and end only via `stop` or reset.
- `PATGEN_LOOP_EN` undefined:
  - The `loop` port is absent and the latched loop flag is constant 0.
  - Every run is one-shot.

## Structure
- Package `patgen_pkg`:
  - State enum (`PG_IDLE`, `PG_RUN`).
  - Default constants for `DEPTH`, `WIDTH` and `DIV_W`.
- Sub-module `patgen_hold_counter`:
  - Loadable down-counter of width `DIV_W`.
  - Inputs: load, load value, enable.
  - Output: `zero` flag, marking the step boundary.
- The pattern memory is a flop array with asynchronous reset, held in the top module.

## Test plan
- Load 1010,0101,1111,0000; `len`=3, `div`=0, `start` at edge 0:
  - `out_data` = 1010, 0101, 1111, 0000 at edges 1–4.
  - `done` high and `busy` low at edge 5; `out_data` = 0 at edge 5.
- Same pattern with `div`=2:
  - Each word held 3 cycles.
  - Steps begin at edges 1, 4, 7, 10; `done` at edge 13.
- `PATGEN_LOOP_EN` with `loop`=1, `len`=1, `div`=0: `out_data` alternates 1010/0101 for at least 20 cycles with no `done`. Then `stop` → `out_data` = 0 and `busy` = 0 on the next edge, and `done` stays low.
- Abort and conflict cases:
  - `start` and `stop` in the same cycle from IDLE → the block stays IDLE.
  - `start` during RUN → ignored; the sequence timing is unchanged.
- Write mem[2]=0001 on the same edge that loads step 2: the output shows the old word. The next run shows 0001.
- Assert `rst_n` low mid-step → all outputs 0 asynchronously and the memory is cleared. After release, a `start` plays all-zero words, with `done` at the expected edge.
